mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the instruction-fetch port (PC side) and the

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_port_arbiter_pick.sv | 19 +
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, access owner and
// a width helper for the down-counters.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select between the fetch and data ports.
// Data wins by default; a starved fetch wins once the counter reaches its limit.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  parameter int SC_W       = cntWidth(STARVE_MAX + 1)
) (
  input  logic            ifReq,
  input  logic            dmReq,
  input  logic [SC_W-1:0] starveCnt,
  output logic            anyReq,
  output logic            grantIf
);

  assign anyReq  = ifReq | dmReq;
  assign grantIf = ifReq & (~dmReq | (starveCnt == SC_W'(STARVE_MAX)));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store,
// sequencing each access over MEM_LAT cycles and returning a one-cycle ack.
//
// state      | meaning
// ARB_IDLE   | no access in flight; sample requests, pick winner, raise strobes
// ARB_ACCESS | strobes held, latency counter running down to zero
// ARB_RESP   | winner's ack high for this single cycle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CNT_W = cntWidth(MEM_LAT);
  localparam int SC_W  = cntWidth(STARVE_MAX + 1);

  if (MEM_LAT < 1) begin : gBadLat
    $error("mem_port_arbiter: MEM_LAT must be at least 1");
  end

  arb_state_t       state;
  arb_owner_t       owner;
  logic [CNT_W-1:0] cnt;
  logic [SC_W-1:0]  starveCnt;
  logic             anyReq;
  logic             grantIf;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SC_W       (SC_W)
  ) uPick (
    .ifReq     (if_req),
    .dmReq     (dm_req),
    .starveCnt (starveCnt),
    .anyReq    (anyReq),
    .grantIf   (grantIf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= OWN_IF;
      cnt       <= '0;
      starveCnt <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (anyReq) begin
            owner     <= grantIf ? OWN_IF : OWN_DM;
            mem_addr  <= grantIf ? if_addr : dm_addr;
            mem_read  <= grantIf | ~dm_we;
            mem_write <= ~grantIf & dm_we;
            cnt       <= CNT_W'(MEM_LAT - 1);
            if (!grantIf) begin
              mem_wdata <= dm_wdata;
            end
            // Only data grants that actually kept a fetch waiting count as starvation.
            if (grantIf) begin
              starveCnt <= '0;
            end else if (if_req && (starveCnt != SC_W'(STARVE_MAX))) begin
              starveCnt <= starveCnt + 1'b1;
            end
            state <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (cnt == '0) begin
            if (mem_read) begin
              if (owner == OWN_IF) begin
                if_rdata <= mem_rdata;
              end else begin
                dm_rdata <= mem_rdata;
              end
            end
            if (owner == OWN_IF) begin
              if_ack <= 1'b1;
            end else begin
              dm_ack <= 1'b1;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= ARB_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) driven by directed
// steps followed by random traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        ifReq     [2];
  logic [31:0] ifAddr    [2];
  logic        ifAck     [2];
  logic [31:0] ifRdata   [2];
  logic        dmReq     [2];
  logic        dmWe      [2];
  logic [31:0] dmAddr    [2];
  logic [31:0] dmWdata   [2];
  logic        dmAck     [2];
  logic [31:0] dmRdata   [2];
  logic [31:0] memAddr   [2];
  logic [31:0] memWdata  [2];
  logic        memRead   [2];
  logic        memWrite  [2];
  logic [31:0] memRdata  [2];
  logic        stall     [2];

  logic [31:0] memImg [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];

  int nAsserts = 0;
  int nFail    = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : gDut
    mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .MEM_LAT    ((k == 0) ? 1 : 3),
      .STARVE_MAX (SMAX)
    ) dut (
      .clk       (clk),
      .rst       (rst[k]),
      .if_req    (ifReq[k]),
      .if_addr   (ifAddr[k]),
      .if_ack    (ifAck[k]),
      .if_rdata  (ifRdata[k]),
      .dm_req    (dmReq[k]),
      .dm_we     (dmWe[k]),
      .dm_addr   (dmAddr[k]),
      .dm_wdata  (dmWdata[k]),
      .dm_ack    (dmAck[k]),
      .dm_rdata  (dmRdata[k]),
      .mem_addr  (memAddr[k]),
      .mem_wdata (memWdata[k]),
      .mem_read  (memRead[k]),
      .mem_write (memWrite[k]),
      .mem_rdata (memRdata[k]),
      .stall     (stall[k])
    );
  end

  function automatic logic [31:0] initVal(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initVal(a);
  endfunction

  // Memory model: addresses settle after the rising edge, data is presented by mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (memWrite[k] === 1'b1) memImg[memAddr[k]] = memWdata[k];
      memRdata[k] = memImg.exists(memAddr[k]) ? memImg[memAddr[k]] : initVal(memAddr[k]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Random traffic on instance d. The model only tracks when the shared memory is
  // free, who is waiting, and how many contested data grants happened in a row.
  task automatic runRandom(input int d, input int lat, input int nCyc, input logic [31:0] base,
                           input logic [31:0] ifHold0, input logic [31:0] dmHold0);
    int          ifAckAt = -100;
    int          dmAckAt = -100;
    int          freeAt  = 0;
    int          starve  = 0;
    bit          ifPend  = 0;
    bit          dmPend  = 0;
    bit          dmW     = 0;
    bit          dmGrantW = 0;
    bit          ifWin;
    bit          expIfAck;
    bit          expDmAck;
    logic [31:0] ifA = base;
    logic [31:0] dmA = base;
    logic [31:0] dmD = '0;
    logic [31:0] ifGrantData = '0;
    logic [31:0] dmGrantData = '0;
    logic [31:0] ifHold = ifHold0;
    logic [31:0] dmHold = dmHold0;
    refMem.delete();
    for (int t = 0; t < nCyc; t++) begin
      nextCycle();
      if (ifPend && ifAckAt == t - 1) ifPend = 0;
      if (dmPend && dmAckAt == t - 1) dmPend = 0;
      if (!ifPend && t < nCyc - 20 && $urandom_range(0, 2) == 0) begin
        ifPend = 1;
        ifA    = base + 32'(4 * $urandom_range(0, 7));
      end
      if (!dmPend && t < nCyc - 20 && $urandom_range(0, 1) == 0) begin
        dmPend = 1;
        dmW    = 1'($urandom_range(0, 1));
        dmA    = base + 32'(4 * $urandom_range(0, 7));
        dmD    = $urandom;
      end
      ifReq[d]   = ifPend;
      ifAddr[d]  = ifA;
      dmReq[d]   = dmPend;
      dmWe[d]    = dmW;
      dmAddr[d]  = dmA;
      dmWdata[d] = dmD;
      sample();
      expIfAck = (ifAckAt == t);
      expDmAck = (dmAckAt == t);
      if (expIfAck) ifHold = ifGrantData;
      if (expDmAck && !dmGrantW) dmHold = dmGrantData;
      chk($sformatf("rnd%0d_if_ack t=%0d", d, t), ifAck[d], expIfAck);
      chk($sformatf("rnd%0d_dm_ack t=%0d", d, t), dmAck[d], expDmAck);
      chk($sformatf("rnd%0d_stall t=%0d", d, t), stall[d],
          (ifPend & ~expIfAck) | (dmPend & ~expDmAck));
      chk($sformatf("rnd%0d_if_rdata t=%0d", d, t), ifRdata[d], ifHold);
      chk($sformatf("rnd%0d_dm_rdata t=%0d", d, t), dmRdata[d], dmHold);
      if (t >= freeAt && (ifPend || dmPend)) begin
        ifWin = ifPend && (!dmPend || starve == SMAX);
        if (ifWin) begin
          ifGrantData = refRead(ifA);
          ifAckAt     = t + lat + 1;
          starve      = 0;
        end else begin
          dmGrantW = dmW;
          if (dmW) refMem[dmA] = dmD;
          else     dmGrantData = refRead(dmA);
          dmAckAt = t + lat + 1;
          if (ifPend && starve < SMAX) starve++;
        end
        freeAt = t + lat + 2;
      end
    end
    nextCycle();
    ifReq[d] = 1'b0;
    dmReq[d] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          got;
    int          nDm;
    logic        grants [8];

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;  ifReq[k] = 1'b0; ifAddr[k] = '0;
      dmReq[k] = 1'b0; dmWe[k] = 1'b0; dmAddr[k] = '0; dmWdata[k] = '0;
    end
    memImg[32'h40]  = 32'h8C220004;
    memImg[32'h200] = 32'h12345678;

    repeat (3) nextCycle();
    sample();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d_mem_read", k),  memRead[k],  0);
      chk($sformatf("rst%0d_mem_write", k), memWrite[k], 0);
      chk($sformatf("rst%0d_if_ack", k),    ifAck[k],    0);
      chk($sformatf("rst%0d_dm_ack", k),    dmAck[k],    0);
      chk($sformatf("rst%0d_mem_addr", k),  memAddr[k],  0);
      chk($sformatf("rst%0d_mem_wdata", k), memWdata[k], 0);
      chk($sformatf("rst%0d_if_rdata", k),  ifRdata[k],  0);
      chk($sformatf("rst%0d_dm_rdata", k),  dmRdata[k],  0);
      chk($sformatf("rst%0d_stall", k),     stall[k],    0);
    end
    nextCycle();
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Fetch only, one-cycle memory
    nextCycle();
    ifReq[0] = 1'b1; ifAddr[0] = 32'h40;
    sample();
    chk("t1_stall_g", stall[0], 1);
    chk("t1_read_g", memRead[0], 0);
    nextCycle(); sample();
    chk("t1_read_g1", memRead[0], 1);
    chk("t1_addr_g1", memAddr[0], 32'h40);
    chk("t1_stall_g1", stall[0], 1);
    chk("t1_ack_g1", ifAck[0], 0);
    nextCycle(); sample();
    chk("t1_ack_g2", ifAck[0], 1);
    chk("t1_rdata_g2", ifRdata[0], 32'h8C220004);
    chk("t1_stall_g2", stall[0], 0);
    chk("t1_read_g2", memRead[0], 0);
    nextCycle();
    ifReq[0] = 1'b0;
    sample();
    chk("t1_ack_g3", ifAck[0], 0);

    // Store
    nextCycle();
    dmReq[0] = 1'b1; dmWe[0] = 1'b1; dmAddr[0] = 32'h100; dmWdata[0] = 32'hDEADBEEF;
    sample();
    nextCycle(); sample();
    chk("t2_write", memWrite[0], 1);
    chk("t2_read", memRead[0], 0);
    chk("t2_addr", memAddr[0], 32'h100);
    chk("t2_wdata", memWdata[0], 32'hDEADBEEF);
    nextCycle(); sample();
    chk("t2_ack", dmAck[0], 1);
    chk("t2_rdata_held", dmRdata[0], 0);
    chk("t2_write_off", memWrite[0], 0);
    nextCycle();
    dmReq[0] = 1'b0; dmWe[0] = 1'b0;
    sample();
    chk("t2_ack_once", dmAck[0], 0);

    // Sustained contention: fetch forced through after three data grants
    nextCycle();
    ifReq[0] = 1'b1; ifAddr[0] = 32'h44;
    dmReq[0] = 1'b1; dmWe[0] = 1'b0; dmAddr[0] = 32'h104;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      sample();
      chk("t3_single_ack", ifAck[0] & dmAck[0], 0);
      if (ifAck[0] || dmAck[0]) begin
        grants[got] = ifAck[0];
        got++;
      end
      nextCycle();
    end
    ifReq[0] = 1'b0;
    dmReq[0] = 1'b0;
    chk("t3_grant_count", got, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_grant%0d_is_if", i), grants[i], (i % 4) == 3);
    end
    sample();

    // Data request withdrawn mid-access still completes; pending fetch follows
    nextCycle();
    dmReq[0] = 1'b1; dmWe[0] = 1'b0; dmAddr[0] = 32'h500;
    ifReq[0] = 1'b1; ifAddr[0] = 32'h600;
    sample();
    nextCycle();
    dmReq[0] = 1'b0;
    sample();
    chk("t6_stall", stall[0], 1);
    chk("t6_addr_dm", memAddr[0], 32'h500);
    nextCycle(); sample();
    chk("t6_dm_ack", dmAck[0], 1);
    chk("t6_dm_rdata", dmRdata[0], initVal(32'h500));
    nextCycle(); sample();
    chk("t6_dm_ack_once", dmAck[0], 0);
    chk("t6_if_ack_early", ifAck[0], 0);
    nextCycle(); sample();
    chk("t6_addr_if", memAddr[0], 32'h600);
    nextCycle(); sample();
    chk("t6_if_ack", ifAck[0], 1);
    chk("t6_if_rdata", ifRdata[0], initVal(32'h600));
    nextCycle();
    ifReq[0] = 1'b0;
    sample();
    chk("t6_no_more_acks", ifAck[0] | dmAck[0], 0);

    runRandom(0, 1, 400, 32'h1000, initVal(32'h600), initVal(32'h500));

    // Three-cycle load
    nextCycle();
    dmReq[1] = 1'b1; dmWe[1] = 1'b0; dmAddr[1] = 32'h200;
    sample();
    chk("t4_read_g", memRead[1], 0);
    for (int i = 1; i <= 3; i++) begin
      nextCycle(); sample();
      chk($sformatf("t4_read_g%0d", i), memRead[1], 1);
      chk($sformatf("t4_addr_g%0d", i), memAddr[1], 32'h200);
      chk($sformatf("t4_ack_g%0d", i), dmAck[1], 0);
    end
    nextCycle(); sample();
    chk("t4_ack_g4", dmAck[1], 1);
    chk("t4_rdata", dmRdata[1], 32'h12345678);
    chk("t4_read_off", memRead[1], 0);
    nextCycle();
    dmReq[1] = 1'b0;
    sample();
    chk("t4_ack_once", dmAck[1], 0);

    // Reset mid-access after the fetch has been starved to the limit
    nextCycle();
    ifReq[1] = 1'b1; ifAddr[1] = 32'h300;
    dmReq[1] = 1'b1; dmWe[1] = 1'b0; dmAddr[1] = 32'h204;
    nDm = 0;
    for (int c = 0; c < 30; c++) begin
      sample();
      chk("t5_if_waits", ifAck[1], 0);
      if (dmAck[1]) nDm++;
      if (nDm == 2) break;
      nextCycle();
    end
    chk("t5_dm_acks_before_rst", nDm, 2);
    nextCycle();
    nextCycle();
    nextCycle();
    rst[1] = 1'b1; ifReq[1] = 1'b0; dmReq[1] = 1'b0;
    sample();
    chk("t5_in_access", memRead[1], 1);
    nextCycle();
    rst[1] = 1'b0;
    sample();
    chk("t5_read_after_rst", memRead[1], 0);
    chk("t5_write_after_rst", memWrite[1], 0);
    chk("t5_addr_after_rst", memAddr[1], 0);
    chk("t5_acks_after_rst", ifAck[1] | dmAck[1], 0);
    nextCycle();
    ifReq[1] = 1'b1; ifAddr[1] = 32'h300;
    dmReq[1] = 1'b1; dmWe[1] = 1'b0; dmAddr[1] = 32'h208;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) nextCycle();
      if (c == 5) dmReq[1] = 1'b0;
      sample();
      chk($sformatf("t5_dm_ack c=%0d", c), dmAck[1], c == 4);
      chk($sformatf("t5_if_ack c=%0d", c), ifAck[1], c == 9);
    end
    chk("t5_dm_rdata", dmRdata[1], initVal(32'h208));
    chk("t5_if_rdata", ifRdata[1], initVal(32'h300));
    nextCycle();
    ifReq[1] = 1'b0;
    sample();
    chk("t5_idle", ifAck[1] | dmAck[1], 0);

    runRandom(1, 3, 400, 32'h2000, initVal(32'h300), initVal(32'h208));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
